// File: rtl/dsp_logic_pkg.sv
// Shared definitions for the DSP logic-unit arbiter slice.
// Provides the bitwise opcode encoding, the opcode field width and a helper
// that sizes requester tags from the requester count.
package dsp_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  localparam int unsigned OP_W = 2;

  // Bits needed to hold a requester index (never less than one).
  function automatic int unsigned tag_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/dsp_logic_unit.sv
// Pipelined bitwise logic datapath, mapped onto one DSP logic-mode slice.
// The result is formed at the input and carried through LATENCY register
// stages together with a valid bit and the requester tag.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_valid/op/a/b/tag    operation issued this cycle
//   out_valid/y/tag        final-stage result; out_y is zero when not valid
module dsp_logic_unit
  import dsp_logic_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_y,
  output logic [TAG_W-1:0] out_tag
);

  logic [WIDTH-1:0]   result;
  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   y_q   [LATENCY];
  logic [TAG_W-1:0]   tag_q [LATENCY];

  always_comb begin
    result = '0;
    unique case (op_e'(in_op))
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_XOR:  result = in_a ^ in_b;
      OP_XNOR: result = ~(in_a ^ in_b);
    endcase
  end

  // Data is zeroed on idle slots so the output needs no extra gating.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        y_q[i]   <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      y_q[0]   <= in_valid ? result : '0;
      tag_q[0] <= in_tag;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        y_q[i]   <= y_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_y     = y_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];

endmodule

// File: rtl/dsp_logic_arbiter.sv
// Round-robin arbiter sharing one pipelined DSP logic unit among NUM_REQ
// requesters. One grant per cycle; the result returns to the owner exactly
// LATENCY cycles after acceptance as a one-cycle strobe.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   req_valid      per-requester request present
//   req_ready      one-hot grant (combinational from req_valid and pointer)
//   req_op/a/b     per-requester opcode and operands, packed by index
//   rsp_valid      one-hot result strobe
//   rsp_y          result, zero when no rsp_valid bit is set
module dsp_logic_arbiter
  import dsp_logic_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [OP_W*NUM_REQ-1:0]  req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_y
);

  localparam int unsigned TAG_W = tag_width(NUM_REQ);

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] winner;
  logic             found;
  logic             grant;
  int unsigned      idx;

  logic             u_valid;
  logic [WIDTH-1:0] u_y;
  logic [TAG_W-1:0] u_tag;

  // Search ptr, ptr+1, ... modulo NUM_REQ; first set request wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx[TAG_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[TAG_W-1:0];
      end
    end
  end

  assign grant     = found & ~reset;
  assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant) begin
      if (winner == TAG_W'(NUM_REQ - 1)) ptr <= '0;
      else                               ptr <= winner + 1'b1;
    end
  end

  dsp_logic_unit #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) u_unit (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (grant),
    .in_op     (req_op[int'(winner)*OP_W +: OP_W]),
    .in_a      (req_a[int'(winner)*WIDTH +: WIDTH]),
    .in_b      (req_b[int'(winner)*WIDTH +: WIDTH]),
    .in_tag    (winner),
    .out_valid (u_valid),
    .out_y     (u_y),
    .out_tag   (u_tag)
  );

  always_comb begin
    rsp_valid = '0;
    if (u_valid) rsp_valid[u_tag] = 1'b1;
  end

  assign rsp_y = u_y;

endmodule

// File: tb/tb_dsp_logic_arbiter.sv
module tb_dsp_logic_arbiter;

  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int LAT = 2;
  localparam int MAXC = 1024;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [2*NR-1:0] req_op;
  logic [W*NR-1:0] req_a;
  logic [W*NR-1:0] req_b;
  logic [NR-1:0]   rsp_valid;
  logic [W-1:0]    rsp_y;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mptr   = 0;
  int nrsp   = 0;

  logic [NR-1:0] exp_rv [MAXC];
  logic [W-1:0]  exp_ry [MAXC];

  always #5 clock = ~clock;

  dsp_logic_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y)
  );

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic step(input logic rst, input logic [NR-1:0] v, input logic [2*NR-1:0] op,
                      input logic [W*NR-1:0] a, input logic [W*NR-1:0] b);
    int win;
    logic [NR-1:0] exp_ready;
    reset = rst; req_valid = v; req_op = op; req_a = a; req_b = b;
    @(negedge clock);
    win = -1;
    exp_ready = '0;
    if (!rst)
      for (int off = 0; off < NR; off++)
        if (win < 0 && v[(mptr + off) % NR]) win = (mptr + off) % NR;
    if (win >= 0) exp_ready[win] = 1'b1;

    checks++;
    assert (req_ready === exp_ready) else begin
      errors++;
      $error("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
    end
    checks++;
    assert (rsp_valid === exp_rv[cyc]) else begin
      errors++;
      $error("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv[cyc]);
    end
    checks++;
    assert (rsp_y === exp_ry[cyc]) else begin
      errors++;
      $error("FAIL rsp_y cyc=%0d got=%h exp=%h", cyc, rsp_y, exp_ry[cyc]);
    end
    if (rsp_valid != '0) nrsp++;

    if (rst) begin
      for (int d = 1; d <= LAT; d++) begin
        exp_rv[cyc + d] = '0;
        exp_ry[cyc + d] = '0;
      end
      mptr = 0;
    end else if (win >= 0) begin
      exp_rv[cyc + LAT] = NR'(1) << win;
      exp_ry[cyc + LAT] = ref_op(op[2*win +: 2], a[W*win +: W], b[W*win +: W]);
      mptr = (win + 1) % NR;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    logic [NR-1:0]   rv;
    logic [2*NR-1:0] rop;
    logic [W*NR-1:0] ra, rb;
    int n0;
    for (int i = 0; i < MAXC; i++) begin
      exp_rv[i] = '0;
      exp_ry[i] = '0;
    end
    reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    @(posedge clock);
    #1;

    // Reset with requests present: nothing granted.
    step(1'b1, 4'b1111, '0, '0, '0);
    step(1'b1, 4'b0101, '0, '0, '0);

    // Requester 0 OR 3|8 = 11.
    step(1'b0, 4'b0001, 8'b00_00_00_01, 32'h00000003, 32'h00000008);
    step(1'b0, 4'b0000, '0, '0, '0);
    step(1'b0, 4'b0000, '0, '0, '0);

    // Requester 1 XOR FF^0F, then requester 3 AND F0&3C.
    step(1'b0, 4'b0010, 8'b00_00_10_00, 32'h0000FF00, 32'h00000F00);
    step(1'b0, 4'b1000, 8'b00_00_00_00, 32'hF0000000, 32'h3C000000);
    step(1'b0, 4'b0000, '0, '0, '0);
    step(1'b0, 4'b0000, '0, '0, '0);

    // All four valid continuously from reset for 8 cycles.
    step(1'b1, 4'b0000, '0, '0, '0);
    n0 = nrsp;
    for (int i = 0; i < 8; i++)
      step(1'b0, 4'b1111, 8'b11_10_01_00, 32'h11223344 + 32'(i), 32'h55667788);
    step(1'b0, 4'b0000, '0, '0, '0);
    step(1'b0, 4'b0000, '0, '0, '0);
    checks++;
    assert (nrsp - n0 == 8) else begin
      errors++;
      $error("FAIL burst_count got=%0d exp=8", nrsp - n0);
    end

    // ptr=1 with only requesters 0 and 2: grants 2, 0, 2.
    step(1'b1, 4'b0000, '0, '0, '0);
    step(1'b0, 4'b0001, '0, 32'h000000AA, 32'h000000FF);
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'b0101, 8'b00_10_00_01, 32'h00550012, 32'h000F0034);

    // Grant then reset mid-pipeline: response discarded, ptr back to 0.
    step(1'b0, 4'b0000, '0, '0, '0);
    step(1'b0, 4'b0100, 8'b00_01_00_00, 32'h00FF0000, 32'h00010000);
    step(1'b1, 4'b0000, '0, '0, '0);
    step(1'b0, 4'b1010, 8'b01_00_01_00, 32'h12003400, 32'h56007800);
    step(1'b0, 4'b0000, '0, '0, '0);
    step(1'b0, 4'b0000, '0, '0, '0);

    // XNOR equal operands, AND giving a zero result.
    step(1'b0, 4'b0001, 8'b00_00_00_11, 32'h000000AA, 32'h000000AA);
    step(1'b0, 4'b0010, 8'b00_00_00_00, 32'h00000000, 32'h0000FF00);
    step(1'b0, 4'b0000, '0, '0, '0);
    step(1'b0, 4'b0000, '0, '0, '0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      rv  = NR'($urandom);
      rop = (2*NR)'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      step($urandom_range(0, 49) == 0, rv, rop, ra, rb);
    end
    step(1'b0, 4'b0000, '0, '0, '0);
    step(1'b0, 4'b0000, '0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
